program_loader: RTL and testbench

Upstream stage of the CPU: streams a program into the 16×8 instruction SRAM before execution. It accepts bytes over a valid/ready handshake and writes them to sequential SRAM addresses starting at 0. While loading, it holds the CPU in reset, then releases it so execution starts from program counter 0. When idle it drives the SRAM in read mode so the CPU fetches normally.

---
 rtl/program_loader.sv | 142 ++++++++++++++
 tb/tb_program_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
//   Streams a program into the instruction SRAM ahead of execution. Bytes
//   arrive over a valid/ready handshake and are written to consecutive
//   addresses from 0. The CPU is held in reset for the whole load and one
//   extra edge after it, so it starts fetching from PC 0.
//
// Ports
//   clk       system clock
//   reset     asynchronous, active-low reset
//   start     load request, sampled only in IDLE
//   len       byte count, sampled with start (0 or >LENGTH means LENGTH)
//   in_valid  upstream byte valid
//   in_data   upstream byte
//   in_ready  byte accepted this cycle when in_valid is also high
//   mem_cs    SRAM chip select
//   mem_we    SRAM write enable
//   mem_addr  SRAM address
//   mem_data  SRAM write data
//   cpu_hold  active-high reset to the CPU
//   busy      load in progress
//   done      one-cycle pulse on completion
//   loaded    bytes written in the current/last load
module program_loader #(
  parameter int ADDR   = 4,
  parameter int WIDTH  = 8,
  parameter int LENGTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ADDR:0]    len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [ADDR-1:0]  mem_addr,
  output logic [WIDTH-1:0] mem_data,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic [ADDR:0]    loaded
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    FLUSH   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [ADDR:0] LEN_MAX = (ADDR+1)'(LENGTH);

  state_t            r_state;
  logic [ADDR-1:0]   r_wr_ptr;
  logic [ADDR:0]     r_loaded;
  logic [ADDR:0]     r_target;
  logic              r_mem_cs;
  logic              r_mem_we;
  logic [ADDR-1:0]   r_mem_addr;
  logic [WIDTH-1:0]  r_mem_data;
  logic              r_cpu_hold;
  logic              r_done;

  logic [ADDR:0]     w_target;
  logic [ADDR:0]     w_loaded_inc;
  logic              w_accept;

  // Zero and oversize requests both mean "fill the whole SRAM", which keeps
  // wr_ptr inside the array for every accepted byte.
  assign w_target     = (len == '0 || len > LEN_MAX) ? LEN_MAX : len;
  assign w_loaded_inc = r_loaded + (ADDR+1)'(1);
  assign w_accept     = in_valid && (r_state == LOAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_loaded   <= '0;
      r_target   <= '0;
      r_mem_cs   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_mem_cs <= 1'b1;
      r_done   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_mem_we <= 1'b0;
          if (start) begin
            r_state    <= LOAD;
            r_wr_ptr   <= '0;
            r_loaded   <= '0;
            r_target   <= w_target;
            r_cpu_hold <= 1'b1;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_wr_ptr;
            r_mem_data <= in_data;
            // After the final byte of a full-depth load this wraps to 0,
            // but the pointer is not used again before the next start.
            r_wr_ptr   <= r_wr_ptr + ADDR'(1);
            r_loaded   <= w_loaded_inc;
            if (w_loaded_inc == r_target) begin
              r_state <= FLUSH;
            end
          end else begin
            r_mem_we <= 1'b0;
          end
        end
        FLUSH: begin
          r_mem_we <= 1'b0;
          r_state  <= RELEASE;
        end
        RELEASE: begin
          r_mem_we   <= 1'b0;
          r_cpu_hold <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready = (r_state == LOAD);
  assign busy     = (r_state != IDLE);
  assign mem_cs   = r_mem_cs;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign cpu_hold = r_cpu_hold;
  assign done     = r_done;
  assign loaded   = r_loaded;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [4:0] len = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, mem_cs, mem_we, cpu_hold, busy, done;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic [4:0] loaded;

  program_loader #(.ADDR(4), .WIDTH(8), .LENGTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .loaded(loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: {addr, data} of every byte the bench hands over.
  logic [11:0] exp_q[$];
  logic [7:0]  last_data;
  bit          have_last = 1'b0;

  always @(negedge clk) begin
    if (reset === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_we", 32'(mem_we), 32'd0);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e[11:8]));
        chk("wr_data", 32'(mem_data), 32'(e[7:0]));
        last_data = e[7:0];
        have_last = 1'b1;
      end
    end else if (reset === 1'b1 && busy === 1'b1 && have_last) begin
      chk("stall_data", 32'(mem_data), 32'(last_data));
    end
  end

  typedef struct {
    logic [4:0]  len;
    logic [31:0] vpat;     // in_valid per LOAD cycle, repeating every 32
    bit          restart;  // hold start high (len=2) during LOAD
    int          exp_n;
  } vec_t;

  vec_t       tbl[7];
  logic [7:0] fixed_bytes[3];

  task automatic run_load(input vec_t v, input bit use_fixed);
    int acc;
    int cyc;
    logic [7:0] d;
    start = 1'b1;
    len   = v.len;
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_hold", 32'(cpu_hold), 32'd1);
    chk("start_ready", 32'(in_ready), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_loaded", 32'(loaded), 32'd0);
    acc = 0;
    cyc = 0;
    while (acc < v.exp_n && cyc < 200) begin
      in_valid = v.vpat[cyc % 32];
      d = use_fixed ? fixed_bytes[acc % 3] : 8'($urandom_range(0, 255));
      in_data = d;
      if (v.restart) begin
        start = 1'b1;
        len   = 5'd2;
      end
      if (in_valid) begin
        exp_q.push_back({4'(acc), d});
        acc++;
      end
      tick();
      cyc++;
      if (acc < v.exp_n) begin
        chk("load_loaded", 32'(loaded), 32'(acc));
        chk("load_hold", 32'(cpu_hold), 32'd1);
        chk("load_ready", 32'(in_ready), 32'd1);
      end
    end
    chk("load_bound", 32'(acc), 32'(v.exp_n));
    // Upstream keeps offering a byte; none may be taken after the last one.
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    chk("flush_ready", 32'(in_ready), 32'd0);
    chk("flush_busy", 32'(busy), 32'd1);
    chk("flush_hold", 32'(cpu_hold), 32'd1);
    chk("flush_loaded", 32'(loaded), 32'(v.exp_n));
    tick();
    chk("rel_we", 32'(mem_we), 32'd0);
    chk("rel_hold", 32'(cpu_hold), 32'd1);
    chk("rel_done", 32'(done), 32'd0);
    chk("rel_busy", 32'(busy), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_hold", 32'(cpu_hold), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_loaded", 32'(loaded), 32'(v.exp_n));
    chk("done_qempty", 32'(exp_q.size()), 32'd0);
    chk("done_cs", 32'(mem_cs), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_cs"}, 32'(mem_cs), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_data"}, 32'(mem_data), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_loaded"}, 32'(loaded), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t rv;
    fixed_bytes[0] = 8'h05;
    fixed_bytes[1] = 8'h46;
    fixed_bytes[2] = 8'h8A;
    tbl[0] = '{len: 5'd3,  vpat: 32'hFFFF_FFFF, restart: 1'b0, exp_n: 3};
    tbl[1] = '{len: 5'd0,  vpat: 32'hFFFF_FFFF, restart: 1'b0, exp_n: 16};
    tbl[2] = '{len: 5'd20, vpat: 32'hFFFF_FFFF, restart: 1'b0, exp_n: 16};
    tbl[3] = '{len: 5'd4,  vpat: 32'h0000_009A, restart: 1'b0, exp_n: 4};
    tbl[4] = '{len: 5'd6,  vpat: 32'hFFFF_FFFF, restart: 1'b1, exp_n: 6};
    tbl[5] = '{len: 5'd1,  vpat: 32'hFFFF_FFFF, restart: 1'b0, exp_n: 1};
    tbl[6] = '{len: 5'd16, vpat: 32'hDB6D_B6DB, restart: 1'b0, exp_n: 16};

    // Reset held across edges, then released.
    tick();
    tick();
    check_all_zero("por");
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("post_rst_cs", 32'(mem_cs), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Asynchronous assertion between edges.
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async");
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rel_cs", 32'(mem_cs), 32'd1);
    chk("rel_busy0", 32'(busy), 32'd0);

    // Table of loads, each start issued in the done cycle of the previous one.
    for (int i = 0; i < 7; i++) begin
      run_load(tbl[i], i == 0);
      if (i % 2 == 1) begin
        tick();
        chk("idle_done_low", 32'(done), 32'd0);
        chk("idle_loaded_held", 32'(loaded), 32'(tbl[i].exp_n));
        chk("idle_cs", 32'(mem_cs), 32'd1);
        chk("idle_we", 32'(mem_we), 32'd0);
      end
    end

    // Reset after 2 of 5 bytes, then a fresh 5-byte load from address 0.
    tick();
    start = 1'b1;
    len   = 5'd5;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      in_valid = 1'b1;
      in_data  = d;
      exp_q.push_back({4'(k), d});
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    have_last = 1'b0;
    #1;
    check_all_zero("midload");
    chk("midload_qempty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("midrel_cs", 32'(mem_cs), 32'd1);
    chk("midrel_busy", 32'(busy), 32'd0);
    rv = '{len: 5'd5, vpat: 32'hFFFF_FFFF, restart: 1'b0, exp_n: 5};
    run_load(rv, 1'b0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
